// File: rtl/spi_arb_pkg.sv
// ---------------------------------------------------------------------------
// spi_arb_pkg
// Shared types and constants for the QSPI read arbiter.
//   spi_arb_state_e : arbiter FSM states (IDLE, START, STREAM, STOP, WAIT)
//   PORT_VIDEO      : index of the high-priority requester (RLE video fetch)
//   PORT_AUX        : index of the low-priority requester (palette/sprite)
//   port_onehot()   : converts a port index into a 2-bit one-hot vector
// ---------------------------------------------------------------------------
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_STOP   = 3'd3,
        ST_WAIT   = 3'd4
    } spi_arb_state_e;

    localparam logic PORT_VIDEO = 1'b0;
    localparam logic PORT_AUX   = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_arb_port.sv
// ---------------------------------------------------------------------------
// spi_arb_port
// Per-requester stream state: an open flag and the resume byte address.
// Ports:
//   clk, rstn     : clock, synchronous active-low reset
//   start_i       : open (or reopen) the stream at addr_i; wins over stop_i
//   addr_i        : start byte address, sampled with start_i
//   stop_i        : close the stream
//   adv_i         : one word was delivered; advance address by one word
//   open_o        : stream currently open
//   addr_o        : next byte address to fetch for this port
// ---------------------------------------------------------------------------
module spi_arb_port #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 24
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  stop_i,
    input  logic                  adv_i,
    output logic                  open_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH_BYTES);

    logic                  open_q;
    logic                  open_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;

    always_comb begin
        open_d = open_q;
        addr_d = addr_q;
        if (start_i) begin
            open_d = 1'b1;
            addr_d = addr_i;
        end else begin
            if (stop_i) open_d = 1'b0;
            // Natural wrap at 2^ADDR_WIDTH is intended.
            if (adv_i)  addr_d = addr_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            open_q <= 1'b0;
            addr_q <= '0;
        end else begin
            open_q <= open_d;
            addr_q <= addr_d;
        end
    end

    assign open_o = open_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/spi_read_arbiter.sv
// ---------------------------------------------------------------------------
// spi_read_arbiter
// Shares one QSPI flash read engine between the video fetcher (port 0, high
// priority) and an auxiliary fetcher (port 1). Sequences start/continue/stop
// of the engine, keeps a resume address per port and routes returned words.
//
// Build option: define SPI_ARB_PREEMPT_EN to let port 0 preempt a port 1
// stream at the next word boundary. Without it port 0 waits until port 1
// closes its stream.
//
// Handshake: there is no back-pressure. rd_start/rd_stop and rd_valid are
// single-cycle pulses; spi_data is consumed in the cycle spi_data_valid is
// high, and rd_data/rd_valid follow one cycle later (registered).
//
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   rd_start[1:0]      : per-port pulse, open stream at rd_addr_N
//   rd_addr_0/1        : start byte address for each port
//   rd_stop[1:0]       : per-port pulse, close stream
//   rd_valid[1:0]      : per-port pulse, rd_data belongs to port N
//   rd_data            : returned word (shared)
//   rd_grant[1:0]      : one-hot port owning the engine (START..STOP)
//   spi_start_read     : pulse, begin read at spi_addr
//   spi_addr           : read byte address
//   spi_continue_read  : level, keep streaming
//   spi_stop_read      : pulse, end the flash transaction
//   spi_data           : word from engine
//   spi_data_valid     : pulse, spi_data holds a word
//   spi_busy           : engine mid-command / mid-word
//   dbg_state_o        : current FSM state
// ---------------------------------------------------------------------------
module spi_read_arbiter
    import spi_arb_pkg::*;
#(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int ADDR_WIDTH       = 24
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [1:0]                    rd_start,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_0,
    input  logic [ADDR_WIDTH-1:0]         rd_addr_1,
    input  logic [1:0]                    rd_stop,
    output logic [1:0]                    rd_valid,
    output logic [DATA_WIDTH_BYTES*8-1:0] rd_data,
    output logic [1:0]                    rd_grant,
    output logic                          spi_start_read,
    output logic [ADDR_WIDTH-1:0]         spi_addr,
    output logic                          spi_continue_read,
    output logic                          spi_stop_read,
    input  logic [DATA_WIDTH_BYTES*8-1:0] spi_data,
    input  logic                          spi_data_valid,
    input  logic                          spi_busy,
    output spi_arb_state_e                dbg_state_o
);

    localparam int DW = DATA_WIDTH_BYTES * 8;

    logic [1:0]            port_open;
    logic [ADDR_WIDTH-1:0] port_addr_0;
    logic [ADDR_WIDTH-1:0] port_addr_1;
    logic [1:0]            port_adv;

    spi_arb_port #(
        .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES),
        .ADDR_WIDTH       (ADDR_WIDTH)
    ) u_port0 (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (rd_start[PORT_VIDEO]),
        .addr_i  (rd_addr_0),
        .stop_i  (rd_stop[PORT_VIDEO]),
        .adv_i   (port_adv[PORT_VIDEO]),
        .open_o  (port_open[PORT_VIDEO]),
        .addr_o  (port_addr_0)
    );

    spi_arb_port #(
        .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES),
        .ADDR_WIDTH       (ADDR_WIDTH)
    ) u_port1 (
        .clk     (clk),
        .rstn    (rstn),
        .start_i (rd_start[PORT_AUX]),
        .addr_i  (rd_addr_1),
        .stop_i  (rd_stop[PORT_AUX]),
        .adv_i   (port_adv[PORT_AUX]),
        .open_o  (port_open[PORT_AUX]),
        .addr_o  (port_addr_1)
    );

    spi_arb_state_e        state_q;
    logic                  gnt_idx_q;
    logic [1:0]            grant_q;
    logic                  restart_pend_q;
    logic                  spi_start_q;
    logic [ADDR_WIDTH-1:0] spi_addr_q;
    logic                  spi_cont_q;
    logic                  spi_stop_q;
    logic [1:0]            rd_valid_q;
    logic [DW-1:0]         rd_data_q;

    logic                  sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  cur_open;
    logic                  start_g;
    logic                  stop_g;
    logic                  word_ok;
    logic                  preempt_req;
    logic                  exit_req;
    logic                  no_inflight;

    always_comb begin
        sel_idx  = port_open[PORT_VIDEO] ? PORT_VIDEO : PORT_AUX;
        sel_addr = sel_idx ? port_addr_1 : port_addr_0;
        cur_open = port_open[gnt_idx_q];
        start_g  = rd_start[gnt_idx_q];
        stop_g   = rd_stop[gnt_idx_q];
        // A word belongs to the granted stream only if that stream is still
        // open and has not been restarted at a new address; otherwise it is
        // left over from the abandoned stream and is dropped.
        word_ok  = (state_q == ST_STREAM) && spi_data_valid && cur_open &&
                   !stop_g && !start_g && !restart_pend_q;
        port_adv = word_ok ? port_onehot(gnt_idx_q) : 2'b00;
`ifdef SPI_ARB_PREEMPT_EN
        preempt_req = (gnt_idx_q == PORT_AUX) && port_open[PORT_VIDEO];
`else
        preempt_req = 1'b0;
`endif
        exit_req    = !cur_open || restart_pend_q || preempt_req;
        // Safe to drop CS only at a word boundary.
        no_inflight = spi_data_valid || !spi_busy;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            gnt_idx_q      <= PORT_VIDEO;
            grant_q        <= 2'b00;
            restart_pend_q <= 1'b0;
            spi_start_q    <= 1'b0;
            spi_addr_q     <= '0;
            spi_cont_q     <= 1'b0;
            spi_stop_q     <= 1'b0;
            rd_valid_q     <= 2'b00;
            rd_data_q      <= '0;
        end else begin
            rd_valid_q  <= port_adv;
            if (word_ok) rd_data_q <= spi_data;
            spi_start_q <= 1'b0;
            spi_stop_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!spi_busy && (|port_open)) begin
                        state_q        <= ST_START;
                        gnt_idx_q      <= sel_idx;
                        grant_q        <= port_onehot(sel_idx);
                        spi_start_q    <= 1'b1;
                        spi_addr_q     <= sel_addr;
                        // A reopen in this very cycle makes the issued address stale.
                        restart_pend_q <= rd_start[sel_idx];
                    end
                end
                ST_START: begin
                    state_q        <= ST_STREAM;
                    spi_cont_q     <= 1'b1;
                    restart_pend_q <= restart_pend_q | start_g;
                end
                ST_STREAM: begin
                    restart_pend_q <= restart_pend_q | start_g;
                    if (exit_req && no_inflight) begin
                        state_q    <= ST_STOP;
                        spi_stop_q <= 1'b1;
                        spi_cont_q <= 1'b0;
                    end
                end
                ST_STOP: begin
                    state_q        <= ST_WAIT;
                    grant_q        <= 2'b00;
                    restart_pend_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!spi_busy) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_valid          = rd_valid_q;
    assign rd_data           = rd_data_q;
    assign rd_grant          = grant_q;
    assign spi_start_read    = spi_start_q;
    assign spi_addr          = spi_addr_q;
    assign spi_continue_read = spi_cont_q;
    assign spi_stop_read     = spi_stop_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_spi_read_arbiter.sv
module tb_spi_read_arbiter;
    import spi_arb_pkg::*;

    logic        clk;
    logic        rstn;
    logic [1:0]  rd_start;
    logic [23:0] rd_addr_0;
    logic [23:0] rd_addr_1;
    logic [1:0]  rd_stop;
    logic [1:0]  rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_grant;
    logic        spi_start_read;
    logic [23:0] spi_addr;
    logic        spi_continue_read;
    logic        spi_stop_read;
    logic [31:0] spi_data;
    logic        spi_data_valid;
    logic        spi_busy;
    spi_arb_state_e dbg_state;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    spi_read_arbiter #(
        .DATA_WIDTH_BYTES (4),
        .ADDR_WIDTH       (24)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .rd_start          (rd_start),
        .rd_addr_0         (rd_addr_0),
        .rd_addr_1         (rd_addr_1),
        .rd_stop           (rd_stop),
        .rd_valid          (rd_valid),
        .rd_data           (rd_data),
        .rd_grant          (rd_grant),
        .spi_start_read    (spi_start_read),
        .spi_addr          (spi_addr),
        .spi_continue_read (spi_continue_read),
        .spi_stop_read     (spi_stop_read),
        .spi_data          (spi_data),
        .spi_data_valid    (spi_data_valid),
        .spi_busy          (spi_busy),
        .dbg_state_o       (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic pulse_start(input int p, input logic [23:0] a);
        if (p == 0) rd_addr_0 = a; else rd_addr_1 = a;
        rd_start[p] = 1'b1;
        tick();
        rd_start = 2'b00;
    endtask

    task automatic pulse_stop(input int p);
        rd_stop[p] = 1'b1;
        tick();
        rd_stop = 2'b00;
    endtask

    // One word from the engine after a short mid-word gap.
    task automatic send_word(input logic [31:0] d, input bit deliver, input int p);
        repeat (2) tick();
        spi_data       = d;
        spi_data_valid = 1'b1;
        if (deliver) exp_q.push_back({(p == 0) ? 2'b01 : 2'b10, d});
        tick();
        spi_data_valid = 1'b0;
    endtask

    task automatic wait_start(input logic [23:0] a, input logic [1:0] g, input string tag);
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (spi_start_read) found = 1;
        end
        chk({tag, "_start_seen"}, 64'(found), 64'd1);
        if (found) begin
            chk({tag, "_spi_addr"}, 64'(spi_addr), 64'(a));
            chk({tag, "_grant"}, 64'(rd_grant), 64'(g));
        end
        tick();
    endtask

    task automatic wait_stop(input logic [1:0] g, input string tag);
        bit found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (spi_stop_read) found = 1;
        end
        chk({tag, "_stop_seen"}, 64'(found), 64'd1);
        if (found) begin
            chk({tag, "_stop_grant"}, 64'(rd_grant), 64'(g));
            chk({tag, "_stop_cont"}, 64'(spi_continue_read), 64'd0);
            @(negedge clk);
            chk({tag, "_post_grant"}, 64'(rd_grant), 64'd0);
        end
        tick();
    endtask

    // scoreboard: every delivered word is compared with the head of exp_q
    always @(negedge clk) begin
        if (rstn && rd_valid !== 2'b00) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("rd_word", 64'({rd_valid, rd_data}), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        bit saw_stop;
        logic [31:0] w;
        rstn = 1'b0;
        rd_start = 2'b00;
        rd_stop = 2'b00;
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        spi_data = '0;
        spi_data_valid = 1'b0;
        spi_busy = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ctl", 64'({rd_valid, rd_grant, spi_start_read, spi_continue_read, spi_stop_read}), 64'd0);
        chk("reset_data", 64'(rd_data), 64'd0);
        chk("reset_addr", 64'(spi_addr), 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        rstn = 1'b1;
        tick();

        // 1: port 0 stream of three words
        pulse_start(0, 24'h000100);
        wait_start(24'h000100, 2'b01, "t1");
        @(negedge clk);
        chk("t1_continue", 64'(spi_continue_read), 64'd1);
        tick();
        spi_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            send_word(w, 1, 0);
        end
        spi_busy = 1'b0;
        tick();
        chk("t1_port0_addr", 64'(dut.u_port0.addr_o), 64'h10C);
        pulse_stop(0);
        wait_stop(2'b01, "t1");

        // 2/3: port 1 streaming, port 0 requests
        pulse_start(1, 24'h002000);
        wait_start(24'h002000, 2'b10, "t2");
        spi_busy = 1'b1;
        send_word(32'hA0A0_0001, 1, 1);
        pulse_start(0, 24'h000040);
`ifdef SPI_ARB_PREEMPT_EN
        send_word(32'hA0A0_0002, 1, 1);
        wait_stop(2'b10, "t2p");
        spi_busy = 1'b0;
        chk("t2p_port1_addr", 64'(dut.u_port1.addr_o), 64'h2008);
        chk("t2p_port1_open", 64'(dut.u_port1.open_o), 64'd1);
        wait_start(24'h000040, 2'b01, "t2p_p0");
        spi_busy = 1'b1;
        send_word(32'hB0B0_0001, 1, 0);
        spi_busy = 1'b0;
        pulse_stop(0);
        wait_stop(2'b01, "t2p_p0");
        wait_start(24'h002008, 2'b10, "t2p_resume");
        pulse_stop(1);
        wait_stop(2'b10, "t2p_resume");
`else
        send_word(32'hA0A0_0002, 1, 1);
        saw_stop = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_stop |= spi_stop_read;
        end
        chk("t3_no_preempt", 64'(saw_stop), 64'd0);
        chk("t3_grant_kept", 64'(rd_grant), 64'b10);
        tick();
        spi_busy = 1'b0;
        pulse_stop(1);
        wait_stop(2'b10, "t3");
        wait_start(24'h000040, 2'b01, "t3_p0");
        pulse_stop(0);
        wait_stop(2'b01, "t3_p0");
`endif

        // 4: stop while a word is in flight; that word is dropped
        pulse_start(0, 24'h000500);
        wait_start(24'h000500, 2'b01, "t4");
        spi_busy = 1'b1;
        send_word(32'hC0C0_0001, 1, 0);
        pulse_stop(0);
        saw_stop = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_stop |= spi_stop_read;
        end
        chk("t4_stop_waits", 64'(saw_stop), 64'd0);
        send_word(32'hDEAD_BEEF, 0, 0);
        wait_stop(2'b01, "t4");
        spi_busy = 1'b0;
        tick();

        // 5: address wrap at the top of flash
        pulse_start(0, 24'hFFFFFC);
        wait_start(24'hFFFFFC, 2'b01, "t5");
        spi_busy = 1'b1;
        send_word(32'h1111_2222, 1, 0);
        chk("t5_wrap_mid", 64'(dut.u_port0.addr_o), 64'h000000);
        send_word(32'h3333_4444, 1, 0);
        chk("t5_wrap_addr", 64'(dut.u_port0.addr_o), 64'h000004);
        spi_busy = 1'b0;
        pulse_stop(0);
        wait_stop(2'b01, "t5");

        // 6: reset mid-stream
        pulse_start(1, 24'h003000);
        wait_start(24'h003000, 2'b10, "t6");
        spi_busy = 1'b1;
        send_word(32'h5555_6666, 1, 1);
        tick();
        rstn = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_ctl", 64'({rd_valid, rd_grant, spi_start_read, spi_continue_read, spi_stop_read}), 64'd0);
        chk("t6_data", 64'(rd_data), 64'd0);
        chk("t6_open", 64'({dut.u_port0.open_o, dut.u_port1.open_o}), 64'd0);
        chk("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        spi_busy = 1'b0;
        tick();
        rstn = 1'b1;
        saw_stop = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            saw_stop |= spi_start_read;
        end
        chk("t6_stays_idle", 64'(saw_stop), 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
